frame_timing_gen: RTL and testbench

//  Single-clock telemetry frame timing generator. Derives a fractional bit-rate tick from the

---
 rtl/frame_timing_gen.sv | 125 ++++++++++++
 tb/tb_frame_timing_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_timing_gen.sv
// Telemetry frame timing: fractional bit tick, 16-tick words, F1/F2/SF/data slot sequencing, data counter.
// Build option FRAME_CLEAR_COUNT_EN: restart the data counter at 0 on every frame start.
module frame_timing_gen #(
    parameter int TICK_NUM  = 2,
    parameter int TICK_DEN  = 5,
    parameter int WORD_BITS = 16
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [15:0] num_word,
    input  logic [15:0] sf_pos,
    input  logic        updown,
    output logic        bit_tick,
    output logic        word_out,
    output logic        signal_f1,
    output logic        signal_f2,
    output logic        signal_sf,
    output logic        signal_d,
    output logic [15:0] word_slot,
    output logic [15:0] count
);
    localparam int BC_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [BC_W-1:0] BIT_LAST     = BC_W'(WORD_BITS - 1);
    localparam logic [BC_W-1:0] BIT_PRE_LAST = BC_W'((WORD_BITS > 1) ? WORD_BITS - 2 : 0);

`ifdef FRAME_CLEAR_COUNT_EN
    localparam bit CLEAR_ON_FRAME = 1'b1;
`else
    localparam bit CLEAR_ON_FRAME = 1'b0;
`endif

    logic [15:0]     acc_q, acc_d;
    logic [16:0]     acc_sum;
    logic            bit_tick_q, bit_tick_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic            word_out_q, word_out_d;
    logic            wrap;
    logic [15:0]     n_words;
    logic [15:0]     slot_q, slot_d;
    logic [15:0]     count_q, count_d;
    logic            ph_f1, ph_f2, ph_sf, ph_d;

    always_comb begin
        acc_sum    = {1'b0, acc_q} + 17'(TICK_NUM);
        bit_tick_d = (acc_sum >= 17'(TICK_DEN));
        acc_d      = bit_tick_d ? 16'(acc_sum - 17'(TICK_DEN)) : acc_sum[15:0];
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (bit_tick_q) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    // bit_cnt follows bit_tick by one clock, so the tick being issued now is the
    // word's last when the already-counted ticks put bit_cnt one short of the end.
    assign wrap       = bit_tick_d && (bit_cnt_d == BIT_PRE_LAST);
    assign word_out_d = wrap;
    assign n_words    = (num_word < 16'd3) ? 16'd3 : num_word;

    always_comb begin
        slot_d = slot_q;
        if (wrap) begin
            slot_d = (slot_q >= n_words - 16'd1) ? 16'd0 : slot_q + 16'd1;
        end
    end

    always_comb begin
        ph_f1 = 1'b0;
        ph_f2 = 1'b0;
        ph_sf = 1'b0;
        ph_d  = 1'b0;
        if (slot_q < n_words) begin
            if (slot_q == 16'd0) begin
                ph_f1 = 1'b1;
            end else if (slot_q == 16'd1) begin
                ph_f2 = 1'b1;
            end else if (slot_q == sf_pos) begin
                ph_sf = 1'b1;
            end else begin
                ph_d = 1'b1;
            end
        end
    end

    // The load strobe sees the old value; the step lands as the strobe cycle ends.
    always_comb begin
        count_d = count_q;
        if (word_out_q && ph_d) begin
            count_d = updown ? count_q + 16'd1 : count_q - 16'd1;
        end
        if (CLEAR_ON_FRAME && wrap && (slot_d == 16'd0)) begin
            count_d = 16'd0;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            acc_q      <= 16'd0;
            bit_tick_q <= 1'b0;
            bit_cnt_q  <= BIT_LAST;
            word_out_q <= 1'b0;
            slot_q     <= 16'hFFFF;
            count_q    <= 16'd0;
        end else begin
            acc_q      <= acc_d;
            bit_tick_q <= bit_tick_d;
            bit_cnt_q  <= bit_cnt_d;
            word_out_q <= word_out_d;
            slot_q     <= slot_d;
            count_q    <= count_d;
        end
    end

    assign bit_tick  = bit_tick_q;
    assign word_out  = word_out_q;
    assign word_slot = slot_q;
    assign count     = count_q;
    assign signal_f1 = ph_f1;
    assign signal_f2 = ph_f2;
    assign signal_sf = ph_sf;
    assign signal_d  = ph_d;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Scoreboard bench for frame_timing_gen: an arithmetic reference model queues expected ticks and
// word loads, a monitor pops and compares them against the DUT outputs.
module tb_frame_timing_gen;
    localparam int TICK_NUM  = 2;
    localparam int TICK_DEN  = 5;
    localparam int WORD_BITS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_word;
    logic [15:0] sf_pos;
    logic        updown;
    logic        bit_tick, word_out, signal_f1, signal_f2, signal_sf, signal_d;
    logic [15:0] word_slot, count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          k;
        int          slot;
        logic [3:0]  ph;
        logic [15:0] cnt;
    } exp_t;

    exp_t wq[$];
    bit   tq[$];

    frame_timing_gen #(
        .TICK_NUM (TICK_NUM),
        .TICK_DEN (TICK_DEN),
        .WORD_BITS(WORD_BITS)
    ) dut (
        .clock_in (clk),
        .reset    (rst),
        .num_word (num_word),
        .sf_pos   (sf_pos),
        .updown   (updown),
        .bit_tick (bit_tick),
        .word_out (word_out),
        .signal_f1(signal_f1),
        .signal_f2(signal_f2),
        .signal_sf(signal_sf),
        .signal_d (signal_d),
        .word_slot(word_slot),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Phase named by a slot index: {d, sf, f2, f1}.
    function automatic logic [3:0] phase_of(int slot, int nw, int sf);
        int n;
        n = (nw < 3) ? 3 : nw;
        if (slot < 0 || slot >= n) return 4'b0000;
        if (slot == 0) return 4'b0001;
        if (slot == 1) return 4'b0010;
        if (slot == sf && sf >= 2) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_bit_tick"}, {31'd0, bit_tick}, 32'd0);
        cmp({tag, "_word_out"}, {31'd0, word_out}, 32'd0);
        cmp({tag, "_word_slot"}, {16'd0, word_slot}, 32'h0000FFFF);
        cmp({tag, "_count"}, {16'd0, count}, 32'd0);
        cmp({tag, "_phases"}, {28'd0, signal_d, signal_sf, signal_f2, signal_f1}, 32'd0);
    endtask

    // Reference model: ticks from floor(k*NUM/DEN), words every WORD_BITS ticks.
    initial begin : model
        int          k;
        int          ticks;
        int          slot;
        int          n;
        logic [15:0] cnt_m;
        bit          pend;
        int          pend_slot;
        exp_t        e;
        k = 0; ticks = 0; slot = -1; cnt_m = 16'd0; pend = 1'b0; pend_slot = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                k = 0; ticks = 0; slot = -1; cnt_m = 16'd0; pend = 1'b0;
            end else begin
                k++;
                if (pend) begin
                    if (phase_of(pend_slot, int'(num_word), int'(sf_pos)) == 4'b1000)
                        cnt_m = cnt_m + (updown ? 16'd1 : 16'hFFFF);
                    pend = 1'b0;
                end
                if ((k * TICK_NUM) / TICK_DEN != ((k - 1) * TICK_NUM) / TICK_DEN) begin
                    tq.push_back(1'b1);
                    ticks++;
                    if (ticks % WORD_BITS == 0) begin
                        n = (int'(num_word) < 3) ? 3 : int'(num_word);
                        slot = (slot < 0 || slot >= n - 1) ? 0 : slot + 1;
`ifdef FRAME_CLEAR_COUNT_EN
                        if (slot == 0) cnt_m = 16'd0;
`endif
                        e.k    = k;
                        e.slot = slot;
                        e.ph   = phase_of(slot, int'(num_word), int'(sf_pos));
                        e.cnt  = cnt_m;
                        wq.push_back(e);
                        pend      = 1'b1;
                        pend_slot = slot;
                    end
                end else begin
                    tq.push_back(1'b0);
                end
            end
        end
    end

    initial begin : monitor
        int   mk;
        exp_t e;
        bit   t;
        mk = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mk = 0;
            end else begin
                mk++;
                if (tq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tick_queue actual=empty required=entry at %0t", $time);
                end else begin
                    t = tq.pop_front();
                    cmp("bit_tick", {31'd0, bit_tick}, {31'd0, t});
                end
                if (word_out) begin
                    if (wq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL word_out actual=1 required=0 (no load due) at %0t", $time);
                    end else begin
                        e = wq.pop_front();
                        cmp("word_clock", mk, e.k);
                        cmp("word_slot", {16'd0, word_slot}, e.slot);
                        cmp("word_phase", {28'd0, signal_d, signal_sf, signal_f2, signal_f1}, {28'd0, e.ph});
                        cmp("word_count", {16'd0, count}, {16'd0, e.cnt});
                    end
                end
            end
        end
    end

    task automatic run_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_mid_word(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        rst      = 1'b1;
        num_word = 16'd10;
        sf_pos   = 16'd4;
        updown   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two full frames counting up, into the third frame's sync word.
        run_clocks(845);

        updown = 1'b0;
        reset_mid_word("midreset_a");
        run_clocks(450);

        num_word = 16'd1;
        sf_pos   = 16'd2;
        updown   = 1'b1;
        run_clocks(250);

        num_word = 16'd10;
        sf_pos   = 16'd12;
        run_clocks(450);

        for (int s = 0; s < 10; s++) begin
            num_word = 16'($urandom_range(0, 20));
            sf_pos   = 16'($urandom_range(0, 22));
            updown   = 1'($urandom_range(0, 1));
            run_clocks($urandom_range(150, 1500));
        end

        num_word = 16'd6;
        sf_pos   = 16'd3;
        reset_mid_word("midreset_b");
        run_clocks(130);

        @(negedge clk);
        cmp("pending_loads", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
